// File: rtl/umi_flex_conv.sv
// Single-clock UMI width converter: splits IDW-wide transactions into ODW-wide
// fragments through a one-entry hold stage feeding a first-word-fall-through FIFO.
module umi_flex_conv #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int IDW   = 256,
  parameter int ODW   = 64,
  parameter int DEPTH = 4,
  parameter int SPLIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chaosmode,
  input  logic                    umi_in_valid,
  input  logic [CW-1:0]           umi_in_cmd,
  input  logic [AW-1:0]           umi_in_dstaddr,
  input  logic [AW-1:0]           umi_in_srcaddr,
  input  logic [IDW-1:0]          umi_in_data,
  output logic                    umi_in_ready,
  output logic                    umi_out_valid,
  output logic [CW-1:0]           umi_out_cmd,
  output logic [AW-1:0]           umi_out_dstaddr,
  output logic [AW-1:0]           umi_out_srcaddr,
  output logic [ODW-1:0]          umi_out_data,
  input  logic                    umi_out_ready,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int OB   = ODW / 8;
  localparam int OBL  = $clog2(OB);
  localparam int AL   = $clog2(DEPTH);
  localparam int CNTW = AL + 1;
  localparam int EW   = CW + 2*AW + ODW;
  localparam logic [2:0]      OBL3    = 3'(OBL);
  localparam logic [15:0]     OB16    = 16'(OB);
  localparam logic [CNTW-1:0] FULLCNT = CNTW'(DEPTH);

  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] REQ_ATOMIC = 5'h09;

  logic            reset_q;
  logic [15:0]     lfsr_q;
  logic            hold_valid_q, hold_valid_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   hold_cmd_q, hold_cmd_d;
  logic [AW-1:0]   hold_dst_q, hold_dst_d;
  logic [AW-1:0]   hold_src_q, hold_src_d;
  logic [IDW-1:0]  hold_data_q, hold_data_d;
  logic [15:0]     hold_rem_q, hold_rem_d;

  logic [2:0]      osize;
  logic [15:0]     room, fb, in_total;
  logic [7:0]      flen;
  logic            fin, wr, last, stall, load, in_is_data;
  logic [CW-1:0]   frag_cmd;

  // Fragment geometry for the current hold contents
  always_comb begin
    osize    = (hold_cmd_q[7:5] > OBL3) ? OBL3 : hold_cmd_q[7:5];
    room     = (SPLIT != 0) ? OB16 - 16'(hold_dst_q[OBL-1:0]) : OB16;
    fb       = (hold_rem_q < room) ? hold_rem_q : room;
    flen     = 8'((fb >> osize) - 16'd1);
    fin      = pass_q | (fb == hold_rem_q);
    frag_cmd = hold_cmd_q;
    if (!pass_q) begin
      frag_cmd[7:5]  = osize;
      frag_cmd[15:8] = flen;
      frag_cmd[21]   = fin & hold_cmd_q[21];
    end
  end

  assign in_is_data = (umi_in_cmd[4:0] == REQ_WRITE)  | (umi_in_cmd[4:0] == REQ_POSTED) |
                      (umi_in_cmd[4:0] == REQ_ATOMIC) | (umi_in_cmd[4:0] == RESP_READ);
  assign in_total   = ({8'h00, umi_in_cmd[15:8]} + 16'd1) << umi_in_cmd[7:5];

  assign stall = chaosmode & ~lfsr_q[0];
  assign wr    = hold_valid_q & ~fifo_full & ~stall;
  assign last  = wr & fin;
  // Live reset term keeps the input closed on the very cycle reset rises
  assign umi_in_ready = ~reset & ~reset_q & (~hold_valid_q | last);
  assign load  = umi_in_valid & umi_in_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    pass_d       = pass_q;
    hold_cmd_d   = hold_cmd_q;
    hold_dst_d   = hold_dst_q;
    hold_src_d   = hold_src_q;
    hold_data_d  = hold_data_q;
    hold_rem_d   = hold_rem_q;
    if (wr) begin
      hold_dst_d  = hold_dst_q + AW'(fb);
      hold_src_d  = hold_src_q + AW'(fb);
      hold_data_d = hold_data_q >> {fb, 3'b000};
      hold_rem_d  = hold_rem_q - fb;
      if (fin) hold_valid_d = 1'b0;
    end
    if (load) begin
      hold_valid_d = 1'b1;
      pass_d       = ~in_is_data;
      hold_cmd_d   = umi_in_cmd;
      hold_dst_d   = umi_in_dstaddr;
      hold_src_d   = umi_in_srcaddr;
      hold_data_d  = umi_in_data;
      hold_rem_d   = in_total;
    end
  end

  always_ff @(posedge clk) begin
    reset_q     <= reset;
    pass_q      <= pass_d;
    hold_cmd_q  <= hold_cmd_d;
    hold_dst_q  <= hold_dst_d;
    hold_src_q  <= hold_src_d;
    hold_data_q <= hold_data_d;
    hold_rem_q  <= hold_rem_d;
    if (reset) begin
      hold_valid_q <= 1'b0;
      lfsr_q       <= 16'hACE1;
    end else begin
      hold_valid_q <= hold_valid_d;
      lfsr_q       <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  // Output FIFO, first-word-fall-through
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   rd_ent;
  logic [AL-1:0]   wp_q, rp_q;
  logic [CNTW-1:0] cnt_q;
  logic            pop;

  assign fifo_full  = (cnt_q == FULLCNT);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_count = cnt_q;
  assign pop        = ~fifo_empty & umi_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + AL'(1);
      if (pop) rp_q <= rp_q + AL'(1);
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= {frag_cmd, hold_dst_q, hold_src_q, hold_data_q[ODW-1:0]};
  end

  assign rd_ent          = fifo_empty ? '0 : mem[rp_q];
  assign umi_out_valid   = ~fifo_empty;
  assign umi_out_cmd     = rd_ent[EW-1 -: CW];
  assign umi_out_dstaddr = rd_ent[2*AW+ODW-1 -: AW];
  assign umi_out_srcaddr = rd_ent[AW+ODW-1 -: AW];
  assign umi_out_data    = rd_ent[ODW-1:0];
endmodule

// File: tb/tb_umi_flex_conv.sv
// Scoreboard bench for umi_flex_conv: one instance without and one with
// address-boundary splitting, sharing stimulus buses but not input valids.
module tb_umi_flex_conv;
  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0, reset = 1'b1, chaosmode = 1'b0;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [31:0] in_cmd = '0;
  logic [63:0] in_dst = '0, in_src = '0;
  logic [255:0] in_data = '0;
  logic ready0, ready1, out_valid0, out_valid1;
  logic [31:0] out_cmd0, out_cmd1;
  logic [63:0] out_dst0, out_dst1, out_src0, out_src1, out_data0, out_data1;
  logic out_ready0 = 1'b1, out_ready1 = 1'b1;
  logic full0, full1, empty0, empty1;
  logic [2:0] count0, count1;
  logic [15:0] lfsr_m;
  beat_t q0[$], q1[$];
  beat_t m0, m1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  umi_flex_conv #(.CW(32), .AW(64), .IDW(256), .ODW(64), .DEPTH(4), .SPLIT(0)) dut0 (
    .clk(clk), .reset(reset), .chaosmode(chaosmode),
    .umi_in_valid(in_valid0), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(ready0),
    .umi_out_valid(out_valid0), .umi_out_cmd(out_cmd0), .umi_out_dstaddr(out_dst0),
    .umi_out_srcaddr(out_src0), .umi_out_data(out_data0), .umi_out_ready(out_ready0),
    .fifo_full(full0), .fifo_empty(empty0), .fifo_count(count0));

  umi_flex_conv #(.CW(32), .AW(64), .IDW(256), .ODW(64), .DEPTH(4), .SPLIT(1)) dut1 (
    .clk(clk), .reset(reset), .chaosmode(chaosmode),
    .umi_in_valid(in_valid1), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(ready1),
    .umi_out_valid(out_valid1), .umi_out_cmd(out_cmd1), .umi_out_dstaddr(out_dst1),
    .umi_out_srcaddr(out_src1), .umi_out_data(out_data1), .umi_out_ready(out_ready1),
    .fifo_full(full1), .fifo_empty(empty1), .fifo_count(count1));

  // Reference LFSR: taps 16,14,13,11, seeded on reset
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  always @(negedge clk) begin
    if (out_valid0 && out_ready0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected: got cmd=%h dst=%h, required no output", out_cmd0, out_dst0);
      end else begin
        m0 = q0.pop_front();
        if ({out_cmd0, out_dst0, out_src0, out_data0} !== {m0.cmd, m0.dst, m0.src, m0.data}) begin
          errors++;
          $display("FAIL dut0_beat: got cmd=%h dst=%h src=%h data=%h, required cmd=%h dst=%h src=%h data=%h",
                   out_cmd0, out_dst0, out_src0, out_data0, m0.cmd, m0.dst, m0.src, m0.data);
        end
      end
    end
    if (out_valid1 && out_ready1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected: got cmd=%h dst=%h, required no output", out_cmd1, out_dst1);
      end else begin
        m1 = q1.pop_front();
        if ({out_cmd1, out_dst1, out_src1, out_data1} !== {m1.cmd, m1.dst, m1.src, m1.data}) begin
          errors++;
          $display("FAIL dut1_beat: got cmd=%h dst=%h src=%h data=%h, required cmd=%h dst=%h src=%h data=%h",
                   out_cmd1, out_dst1, out_src1, out_data1, m1.cmd, m1.dst, m1.src, m1.data);
        end
      end
    end
  end

  function automatic logic [31:0] mkcmd(input logic [4:0] op, input logic [2:0] sz,
                                        input logic [7:0] len, input logic eom);
    logic [31:0] c;
    c = 32'hB4A5_0000;
    c[21] = eom; c[15:8] = len; c[7:5] = sz; c[4:0] = op;
    return c;
  endfunction

  function automatic logic [255:0] in_bytes(input logic [7:0] base);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  function automatic beat_t mkbeat(input logic [31:0] c, input logic [63:0] dst,
                                   input logic [63:0] src, input logic [63:0] data);
    beat_t b;
    b.cmd = c; b.dst = dst; b.src = src; b.data = data;
    return b;
  endfunction

  // Called just after a negedge; returns at the negedge following acceptance
  task automatic send(input bit sel, input logic [31:0] c, input logic [63:0] dst,
                      input logic [63:0] src, input logic [255:0] d);
    bit ok = 0;
    in_cmd = c; in_dst = dst; in_src = src; in_data = d;
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if ((sel ? ready1 : ready0) === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok) @(negedge clk);
    else begin
      errors++;
      $display("FAIL send_timeout: dst=%h not accepted within 50 cycles", dst);
    end
  endtask

  task automatic drain(input bit sel);
    for (int t = 0; t < 200; t++) begin
      if ((sel ? q1.size() : q0.size()) == 0) break;
      @(negedge clk);
    end
    checks++;
    if ((sel ? q1.size() : q0.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sel ? q1.size() : q0.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid0, out_cmd0, out_dst0, out_src0, out_data0} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b cmd=%h, required all zero", out_valid0, out_cmd0);
    end
    checks++;
    if ({empty0, full0, count0} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_status: empty=%b full=%b count=%0d, required 1 0 0", empty0, full0, count0);
    end
    checks++;
    if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready0); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", ready0); end
  endtask

  task automatic test_split_off();
    logic [255:0] d = in_bytes(8'h00);
    out_ready0 = 1'b1;
    for (int k = 0; k < 4; k++)
      q0.push_back(mkbeat(mkcmd(5'h03, 3'd0, 8'd7, k == 3), 64'h1000 + 64'(8*k),
                          64'h8000 + 64'(8*k), d[64*k +: 64]));
    send(0, mkcmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h1000, 64'h8000, d);
    in_valid0 = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL latency_early: valid=%b, required 0", out_valid0); end
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1) begin errors++; $display("FAIL latency_first: valid=%b, required 1", out_valid0); end
    drain(0);
  endtask

  task automatic test_split_on();
    logic [255:0] d = in_bytes(8'h40);
    logic [255:0] s;
    int off[3] = '{0, 4, 12};
    int len[3] = '{3, 7, 3};
    for (int k = 0; k < 3; k++) begin
      s = d >> (8 * off[k]);
      q1.push_back(mkbeat(mkcmd(5'h03, 3'd0, 8'(len[k]), k == 2), 64'h1004 + 64'(off[k]),
                          64'h9004 + 64'(off[k]), s[63:0]));
    end
    send(1, mkcmd(5'h03, 3'd0, 8'd15, 1'b1), 64'h1004, 64'h9004, d);
    in_valid1 = 1'b0;
    drain(1);
  endtask

  task automatic test_read();
    logic [255:0] d = in_bytes(8'h20);
    logic [31:0] c = mkcmd(5'h01, 3'd0, 8'd63, 1'b1);
    q0.push_back(mkbeat(c, 64'h2000, 64'h7000, d[63:0]));
    send(0, c, 64'h2000, 64'h7000, d);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL read_ready_next: got %b, required 1", ready0); end
    in_valid0 = 1'b0;
    drain(0);
  endtask

  task automatic test_size4();
    logic [255:0] d = in_bytes(8'h80);
    for (int k = 0; k < 4; k++)
      q0.push_back(mkbeat(mkcmd(5'h03, 3'd3, 8'd0, k == 3), 64'h3000 + 64'(8*k),
                          64'hA000 + 64'(8*k), d[64*k +: 64]));
    send(0, mkcmd(5'h03, 3'd4, 8'd1, 1'b1), 64'h3000, 64'hA000, d);
    in_valid0 = 1'b0;
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = in_bytes(8'(16*i + 3));
      q0.push_back(mkbeat(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h5000 + 64'(8*i), 64'hB000, d[63:0]));
      checks++;
      if (ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, ready0); end
      send(0, mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h5000 + 64'(8*i), 64'hB000, d);
    end
    in_valid0 = 1'b0;
    drain(0);
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    out_ready0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = in_bytes(8'(8*i + 1));
      q0.push_back(mkbeat(mkcmd(5'h03, 3'd3, 8'd0, 1'b1), 64'h6000 + 64'(8*i), 64'hC000, d[63:0]));
      if (i == 5) begin
        in_cmd = mkcmd(5'h03, 3'd3, 8'd0, 1'b1); in_dst = 64'h6028; in_src = 64'hC000;
        in_data = d; in_valid0 = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({ready0, full0, empty0, out_valid0} !== 4'b0101) begin
          errors++;
          $display("FAIL bp_status: ready=%b full=%b empty=%b valid=%b, required 0 1 0 1",
                   ready0, full0, empty0, out_valid0);
        end
        checks++;
        if (count0 !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d, required 4", count0); end
        checks++;
        if (out_data0 !== q0[0].data || out_dst0 !== q0[0].dst) begin
          errors++;
          $display("FAIL bp_head_stable: data=%h dst=%h, required data=%h dst=%h",
                   out_data0, out_dst0, q0[0].data, q0[0].dst);
        end
        out_ready0 = 1'b1;
      end
      send(0, mkcmd(5'h03, 3'd3, 8'd0, 1'b1), 64'h6000 + 64'(8*i), 64'hC000, d);
    end
    in_valid0 = 1'b0;
    drain(0);
  endtask

  task automatic test_reset_mid();
    out_ready0 = 1'b0;
    send(0, mkcmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h1000, 64'h8000, in_bytes(8'h55));
    in_valid0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (count0 !== 3'd2) begin errors++; $display("FAIL mid_count_before: got %0d, required 2", count0); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({count0, out_valid0, empty0, ready0} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%b empty=%b ready=%b, required 0 0 1 0",
               count0, out_valid0, empty0, ready0);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b, required 1", ready0); end
    out_ready0 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL mid_stray: valid=%b, required 0", out_valid0); end
  endtask

  task automatic test_chaos();
    int n_in = 0, n_wr = 0, outs = 0, first = -1, lastc = -1;
    bit prev_push = 0, hold, push, rdy;
    logic [255:0] d;
    chaosmode = 1'b1;
    out_ready0 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== prev_push) begin
        errors++; $display("FAIL chaos_valid@%0d: got %b, required %b", c, out_valid0, prev_push);
      end
      if (out_valid0 === 1'b1) begin
        outs++; lastc = c;
        if (first < 0) first = c;
      end
      if (n_wr == 16 && !prev_push) break;
      hold = n_in > n_wr;
      push = hold && lfsr_m[0];
      rdy  = !hold || push;
      checks++;
      if (ready0 !== rdy) begin
        errors++; $display("FAIL chaos_ready@%0d: got %b, required %b", c, ready0, rdy);
      end
      if (n_in < 16) begin
        d = in_bytes(8'(n_in * 7));
        in_cmd = mkcmd(5'h03, 3'd3, 8'd0, 1'b1);
        in_dst = 64'h4000 + 64'(8*n_in); in_src = 64'hD000; in_data = d;
        in_valid0 = 1'b1;
        if (rdy) begin
          q0.push_back(mkbeat(in_cmd, in_dst, in_src, d[63:0]));
          n_in++;
        end
      end else in_valid0 = 1'b0;
      if (push) n_wr++;
      prev_push = push;
    end
    in_valid0 = 1'b0;
    chaosmode = 1'b0;
    checks++;
    if (outs != 16) begin errors++; $display("FAIL chaos_count: got %0d beats, required 16", outs); end
    checks++;
    if (lastc - first + 1 <= 16) begin
      errors++; $display("FAIL chaos_span: got %0d cycles, required more than 16", lastc - first + 1);
    end
    drain(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_split_off();
    test_split_on();
    test_read();
    test_size4();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_chaos();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
